// File: rtl/histogram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : histogram_pkg
// Description : Shared types and width helpers for the histogram accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package histogram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    // Channel field width; a single channel still carries a 1-bit field.
    function automatic int cw_of(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

    function automatic int law_of(input int aw, input int nch);
        return aw + cw_of(nch);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hist_ram.sv
`default_nettype none
// ============================================================================
// Module      : hist_ram
// Description : Counter storage, one write port and two read-first sync reads.
// Revision    : 1.0 - initial release
// ============================================================================
module hist_ram #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9,
    parameter int DW     = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DW-1:0]     wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DW-1:0]     rdata_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DW-1:0]     rdata_b
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_a_q;
    logic [DW-1:0] rdata_b_q;

    // A read colliding with the write on the same edge returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re_a) begin
            rdata_a_q <= mem[raddr_a];
        end
        if (re_b) begin
            rdata_b_q <= mem[raddr_b];
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;

endmodule
`default_nettype wire

// File: rtl/histogram_v2.sv
`default_nettype none
// ============================================================================
// Module      : histogram_v2
// Description : Multi-channel saturating histogram with sweep clear and readout.
// Revision    : 1.0 - initial release
// ============================================================================
module histogram_v2
    import histogram_pkg::*;
#(
    parameter int  AW  = 8,
    parameter int  DW  = 16,
    parameter int  NCH = 2,
    localparam int CW  = cw_of(NCH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [CW-1:0] s_ch,
    input  logic [AW-1:0] s_bin,
    input  logic          clr_req,
    output logic          clr_busy,
    input  logic          rd_en,
    input  logic [CW-1:0] rd_ch,
    input  logic [AW-1:0] rd_bin,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic [NCH-1:0] sat
);

    localparam int              LAW       = law_of(AW, NCH);
    localparam int              DEPTH     = NCH * (2 ** AW);
    localparam logic [LAW-1:0]  LAST_ADDR = LAW'(DEPTH - 1);
    localparam logic [DW-1:0]   CNT_MAX   = '1;
    localparam logic [CW:0]     NCH_LIM   = (CW + 1)'(NCH);

    state_e          state_q, state_d;
    logic [LAW-1:0]  sweep_q, sweep_d;
    logic            s2_valid_q, s2_valid_d;
    logic [LAW-1:0]  s2_addr_q, s2_addr_d;
    logic [CW-1:0]   s2_ch_q, s2_ch_d;
    logic            fwd_q, fwd_d;
    logic [DW-1:0]   fwd_val_q, fwd_val_d;
    logic [NCH-1:0]  sat_q, sat_d;
    logic            rd_valid_q, rd_valid_d;
    logic            rd_zero_q, rd_zero_d;

    logic            w_idle;
    logic            w_accept;
    logic            w_s_in_range;
    logic            w_rd_in_range;
    logic            w_rd_take;
    logic            w_clear_now;
    logic [LAW-1:0]  w_s_addr;
    logic [DW-1:0]   w_old;
    logic [DW-1:0]   w_new;
    logic            w_at_max;
    logic            w_inc_we;

    logic            ram_we;
    logic [LAW-1:0]  ram_waddr;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   ram_rdata_a;
    logic [DW-1:0]   ram_rdata_b;

    assign w_idle        = (state_q == ST_IDLE);
    assign w_accept      = s_valid & w_idle;
    assign w_s_in_range  = ({1'b0, s_ch} < NCH_LIM);
    assign w_rd_in_range = ({1'b0, rd_ch} < NCH_LIM);
    assign w_rd_take     = rd_en & w_idle;
    assign w_clear_now   = w_idle & clr_req;
    assign w_s_addr      = {s_ch, s_bin};

    // Stage-2 old value: the memory word, or the value the previous sample
    // wrote on the same edge this sample's read was issued.
    assign w_old    = fwd_q ? fwd_val_q : ram_rdata_a;
    assign w_at_max = (w_old == CNT_MAX);
    assign w_new    = w_at_max ? w_old : w_old + 1'b1;
    assign w_inc_we = s2_valid_q & ~w_clear_now;

    assign ram_we    = rst & (w_idle ? w_inc_we : 1'b1);
    assign ram_waddr = w_idle ? s2_addr_q : sweep_q;
    assign ram_wdata = w_idle ? w_new : '0;

    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        s2_valid_d = w_accept & w_s_in_range;
        s2_addr_d  = w_s_addr;
        s2_ch_d    = s_ch;
        fwd_d      = w_inc_we & (w_s_addr == s2_addr_q);
        fwd_val_d  = w_new;
        sat_d      = sat_q;
        rd_valid_d = w_rd_take;
        rd_zero_d  = rd_zero_q;

        if (w_rd_take) begin
            rd_zero_d = ~w_rd_in_range;
        end
        if (w_inc_we && w_at_max) begin
            sat_d[s2_ch_q] = 1'b1;
        end

        case (state_q)
            ST_CLEAR: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    sweep_d = '0;
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    state_d    = ST_CLEAR;
                    sweep_d    = '0;
                    s2_valid_d = 1'b0;
                    fwd_d      = 1'b0;
                    sat_d      = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                sweep_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_CLEAR;
            sweep_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_addr_q  <= '0;
            s2_ch_q    <= '0;
            fwd_q      <= 1'b0;
            fwd_val_q  <= '0;
            sat_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_zero_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            s2_valid_q <= s2_valid_d;
            s2_addr_q  <= s2_addr_d;
            s2_ch_q    <= s2_ch_d;
            fwd_q      <= fwd_d;
            fwd_val_q  <= fwd_val_d;
            sat_q      <= sat_d;
            rd_valid_q <= rd_valid_d;
            rd_zero_q  <= rd_zero_d;
        end
    end

    hist_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (LAW),
        .DW     (DW)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .re_a    (w_accept & w_s_in_range),
        .raddr_a (w_s_addr),
        .rdata_a (ram_rdata_a),
        .re_b    (w_rd_take & w_rd_in_range),
        .raddr_b ({rd_ch, rd_bin}),
        .rdata_b (ram_rdata_b)
    );

    assign s_ready  = w_idle;
    assign clr_busy = ~w_idle;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_zero_q ? '0 : ram_rdata_b;
    assign sat      = sat_q;

endmodule
`default_nettype wire
